// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the master and by the AHB slaves.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // The bus is 32 bits wide, so anything larger than a word is issued as a word.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > HSIZE_WORD) ? HSIZE_WORD : size;
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: command port -> two-stage address/data pipeline.
// Optional ERROR-response handling is enabled by defining AHB_MASTER_ERR_EN.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [1:0]  htrans,
  output logic        hmastlock,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  logic        a_valid;
  logic [31:0] a_addr;
  logic        a_write;
  logic [2:0]  a_size;
  logic [31:0] a_wdata;

  logic        d_valid;
  logic        d_write;
  logic [31:0] d_wdata;

  logic        err_hold;
  logic        accept;
  logic        addr_move;

  // Command handshake: a command transfers on any edge where cmd_valid and
  // cmd_ready are both high; responses are a single-cycle rsp_valid pulse.
  assign cmd_ready = ~reset & ~err_hold & (~a_valid | hready);
  assign accept    = cmd_valid & cmd_ready;
  assign addr_move = hready & ~err_hold;

  assign haddr     = a_addr;
  assign hwrite    = a_write;
  assign hsize     = a_size;
  assign htrans    = (a_valid && !err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwdata    = d_wdata;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_VAL;
  assign hmastlock = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid   <= 1'b0;
      a_addr    <= 32'h0;
      a_write   <= 1'b0;
      a_size    <= HSIZE_WORD;
      a_wdata   <= 32'h0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      d_wdata   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      if (accept) begin
        a_valid <= 1'b1;
        a_addr  <= cmd_addr;
        a_write <= cmd_write;
        a_size  <= clamp_size(cmd_size);
        a_wdata <= cmd_wdata;
      end else if (addr_move) begin
        a_valid <= 1'b0;
      end

      // A held (cancelled) address phase never reaches the data stage.
      if (hready) begin
        d_valid <= a_valid & ~err_hold;
        if (a_valid && !err_hold) begin
          d_write <= a_write;
          d_wdata <= a_wdata;
        end
      end

      rsp_valid <= d_valid & hready;
      rsp_rdata <= (d_valid && hready && !d_write) ? hrdata : 32'h0;
    end
  end

`ifdef AHB_MASTER_ERR_EN
  // First ERROR cycle arms err_hold, which cancels the pending address phase;
  // the second cycle (hready high) completes the errored transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_hold <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (d_valid && hresp && !hready && !err_hold) begin
        err_hold <= 1'b1;
      end else if (hready) begin
        err_hold <= 1'b0;
      end
      rsp_err <= d_valid & hready & hresp;
    end
  end
`else
  logic unused_hresp;
  assign unused_hresp = hresp;
  assign err_hold     = 1'b0;
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'b0011, constant driven on hprot (non-cacheable privileged data).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  requester has a command.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at an edge.
REQ-006 SHALL have ports cmd_write (input, 1, 1 = write), cmd_addr (input, 32, byte address), cmd_size (input, 3, AHB hsize encoding) and cmd_wdata (input, 32, write data on correct byte lanes).
REQ-007 SHALL have ports rsp_valid (output, 1, one-cycle completion pulse, no backpressure), rsp_rdata (output, 32, read data) and rsp_err (output, 1, error completion).
REQ-008 SHALL have AHB-Lite outputs haddr[32], hwrite[1], hsize[3], hburst[3], hprot[4], htrans[2], hmastlock[1] and hwdata[32].
REQ-009 SHALL have AHB-Lite inputs hrdata[32], hready[1] and hresp[1].

Function
REQ-010 SHALL issue only SINGLE NONSEQ transfers: hburst=3'b000, hmastlock=0, htrans is IDLE (2'b00) or NONSEQ (2'b10).
REQ-011 SHALL keep a two-stage pipeline: an address stage (drives haddr/hwrite/hsize/htrans) and a data stage (drives hwdata, awaits hready).
REQ-012 SHALL assert cmd_ready = ~reset & ~err_hold & (address stage empty | hready).
REQ-013 SHALL load the address stage on accept, driving NONSEQ from the next cycle; with no accept and hready=1 the address stage empties and htrans=IDLE.
REQ-014 SHALL hold address-stage outputs stable while hready=0.
REQ-015 SHALL move the address stage to the data stage on an edge with hready=1, driving hwdata=cmd_wdata of that transfer for the whole data phase.
REQ-016 SHALL complete the data stage on an edge with hready=1, pulsing rsp_valid the next cycle with rsp_rdata=hrdata sampled at that edge (0 for writes).
REQ-017 SHALL give zero-wait-state latency of 2 edges from accept to rsp_valid and sustain one transfer per cycle back-to-back; each wait state adds one cycle.
REQ-018 SHALL clamp cmd_size>3'b010 to 3'b010; address alignment is the requester's duty.
REQ-019 SHALL emit responses strictly in command order, exactly one per accepted command.

Reset
REQ-020 SHALL, while reset is high at an edge, drive haddr=0, hwrite=0, hsize=3'b010, htrans=IDLE, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and clear both stages and err_hold.
REQ-021 SHALL drop in-flight transfers on mid-operation reset with no response; cmd_ready=0 while reset is high.

Configuration
REQ-022 SHALL, with AHB_MASTER_ERR_EN defined, treat hresp=1 & hready=0 in the data phase as the first ERROR cycle: drive htrans=IDLE next cycle, hold any address-stage command pending (err_hold=1) and deassert cmd_ready.
REQ-023 SHALL, with AHB_MASTER_ERR_EN defined, on the second ERROR cycle (hresp=1 & hready=1) pulse rsp_valid with rsp_err=1, clear err_hold and re-issue the held command as NONSEQ the following cycle.
REQ-024 SHALL, without AHB_MASTER_ERR_EN, ignore hresp, tie rsp_err to 0 and leave err_hold constant 0.

Structure
REQ-025 SHALL take HTRANS_IDLE/NONSEQ, HBURST_SINGLE and HSIZE_BYTE/HALF/WORD from shared package ahb_pkg, also used by the AHB slaves.
REQ-026 SHALL be a single module with no sub-module; both pipeline stages are inline registers.

Verification
REQ-027 SHALL cover: read 0x00000200 from the boot ROM slave with zero wait -> rsp_valid 2 cycles after accept, rsp_rdata=32'h2000006f, rsp_err=0.
REQ-028 SHALL cover: reads 0x400, 0x404, 0x408 back-to-back -> NONSEQ on 3 consecutive cycles, rdata 32'h00000693, 32'h800005b7, 32'h017d8637 in order.
REQ-029 SHALL cover: write 0x80000000 data 32'h000000a5 with 3 wait states -> hwdata stable 4 cycles, next haddr held, rsp_valid at accept+5.
REQ-030 SHALL cover (ERR_EN): read 0x10 errors while a read of 0x14 sits in the address stage -> htrans IDLE, rsp_err=1 for 0x10, then 0x14 re-issued and completed with rsp_err=0.
REQ-031 SHALL cover: reset asserted during a waited data phase -> all outputs at REQ-020 values next cycle, no rsp_valid afterwards.
